// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: position, blanking, sync and frame strobes.
`timescale 1ns/1ps
interface vga_timing_gen_if;
   logic        pix_tick;
   logic [9:0]  pos_h;
   logic [9:0]  pos_v;
   logic        blank;
   logic        hsync;
   logic        vsync;
   logic        update;
   logic [15:0] frame_cnt;

   modport master (
      output pix_tick, pos_h, pos_v, blank, hsync, vsync, update, frame_cnt
   );

   modport slave (
      input pix_tick, pos_h, pos_v, blank, hsync, vsync, update, frame_cnt
   );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: clock-enable pixel divider, horizontal/vertical
// region FSMs, registered sync/blank/position outputs and a per-frame update strobe.
`timescale 1ns/1ps
module vga_timing_gen #(
   parameter int unsigned CLK_DIV  = 4,
   parameter int unsigned H_VIS    = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_VIS    = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter bit          SYNC_POL = 1'b0
) (
   input logic              clk,
   input logic              rst,
   vga_timing_gen_if.master vga
);

   localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_ACT_END = 10'(H_VIS - 1);
   localparam logic [9:0] H_FP_END  = 10'(H_VIS + H_FP - 1);
   localparam logic [9:0] H_SY_END  = 10'(H_VIS + H_FP + H_SYNC - 1);
   localparam logic [9:0] H_LAST    = 10'(H_TOT - 1);
   localparam logic [9:0] V_ACT_END = 10'(V_VIS - 1);
   localparam logic [9:0] V_FP_END  = 10'(V_VIS + V_FP - 1);
   localparam logic [9:0] V_SY_END  = 10'(V_VIS + V_FP + V_SYNC - 1);
   localparam logic [9:0] V_LAST    = 10'(V_TOT - 1);
   localparam logic [4:0] DIV_LAST  = 5'(CLK_DIV - 1);

   typedef enum logic [1:0] {HS_ACTIVE, HS_FRONT, HS_SYNC, HS_BACK} h_state_t;
   typedef enum logic [1:0] {VS_ACTIVE, VS_FRONT, VS_SYNC, VS_BACK} v_state_t;

   logic [4:0]  div;
   logic        adv;
   h_state_t    h_state, h_state_nxt;
   v_state_t    v_state, v_state_nxt;
   logic [9:0]  pos_h, pos_v, h_nxt, v_nxt;
   logic        h_wrap, v_wrap;
   logic        pix_tick, blank, hsync, vsync, update;
   logic [15:0] frame_cnt;

   assign adv = (div == DIV_LAST);

   // Next raster position and region; equals the current one when adv is low.
   always_comb begin
      h_nxt       = pos_h;
      v_nxt       = pos_v;
      h_state_nxt = h_state;
      v_state_nxt = v_state;
      h_wrap      = 1'b0;
      v_wrap      = 1'b0;
      if (adv) begin
         h_wrap = (pos_h == H_LAST);
         h_nxt  = h_wrap ? '0 : pos_h + 10'd1;
         case (h_state)
            HS_ACTIVE: if (pos_h == H_ACT_END) h_state_nxt = HS_FRONT;
            HS_FRONT:  if (pos_h == H_FP_END)  h_state_nxt = HS_SYNC;
            HS_SYNC:   if (pos_h == H_SY_END)  h_state_nxt = HS_BACK;
            HS_BACK:   if (h_wrap)             h_state_nxt = HS_ACTIVE;
         endcase
         if (h_wrap) begin
            v_wrap = (pos_v == V_LAST);
            v_nxt  = v_wrap ? '0 : pos_v + 10'd1;
            case (v_state)
               VS_ACTIVE: if (pos_v == V_ACT_END) v_state_nxt = VS_FRONT;
               VS_FRONT:  if (pos_v == V_FP_END)  v_state_nxt = VS_SYNC;
               VS_SYNC:   if (pos_v == V_SY_END)  v_state_nxt = VS_BACK;
               VS_BACK:   if (v_wrap)             v_state_nxt = VS_ACTIVE;
            endcase
         end
      end
   end

   // Every output is decoded from the next state so all of them describe the same pixel.
   always_ff @(posedge clk) begin
      if (rst) begin
         div       <= '0;
         h_state   <= HS_ACTIVE;
         v_state   <= VS_ACTIVE;
         pos_h     <= '0;
         pos_v     <= '0;
         pix_tick  <= 1'b0;
         blank     <= 1'b0;
         hsync     <= ~SYNC_POL;
         vsync     <= ~SYNC_POL;
         update    <= 1'b0;
         frame_cnt <= '0;
      end else begin
         div       <= adv ? '0 : div + 5'd1;
         h_state   <= h_state_nxt;
         v_state   <= v_state_nxt;
         pos_h     <= h_nxt;
         pos_v     <= v_nxt;
         pix_tick  <= adv;
         blank     <= (h_state_nxt != HS_ACTIVE) || (v_state_nxt != VS_ACTIVE);
         hsync     <= (h_state_nxt == HS_SYNC) ? SYNC_POL : ~SYNC_POL;
         vsync     <= (v_state_nxt == VS_SYNC) ? SYNC_POL : ~SYNC_POL;
         update    <= h_wrap && (pos_v == V_ACT_END);
         frame_cnt <= frame_cnt + 16'(v_wrap);
      end
   end

   assign vga.pix_tick  = pix_tick;
   assign vga.pos_h     = pos_h;
   assign vga.pos_v     = pos_v;
   assign vga.blank     = blank;
   assign vga.hsync     = hsync;
   assign vga.vsync     = vsync;
   assign vga.update    = update;
   assign vga.frame_cnt = frame_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: closed-form raster model scoreboard on three configurations,
// a hand-derived checkpoint table and sequences for strobes, widths and mid-frame reset.
`timescale 1ns/1ps
module tb_vga_timing_gen;

   typedef struct packed {
      logic        pix_tick;
      logic [9:0]  pos_h;
      logic [9:0]  pos_v;
      logic        blank;
      logic        hsync;
      logic        vsync;
      logic        update;
      logic [15:0] frame_cnt;
   } exp_t;

   typedef struct {
      int   k;
      exp_t e;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   vga_timing_gen_if ia ();
   vga_timing_gen_if ib ();
   vga_timing_gen_if ic ();

   // Small geometry so whole frames fit in a short run: 25 x 17 pixels.
   vga_timing_gen #(
      .CLK_DIV(4), .H_VIS(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
      .V_VIS(10), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b0)
   ) dut_a (.clk(clk), .rst(rst), .vga(ia));

   vga_timing_gen #(
      .CLK_DIV(1), .H_VIS(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
      .V_VIS(10), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b1)
   ) dut_b (.clk(clk), .rst(rst), .vga(ib));

   vga_timing_gen #(.CLK_DIV(4)) dut_c (.clk(clk), .rst(rst), .vga(ic));

   int   total = 0;
   int   bad   = 0;
   int   kcnt  = 0;
   bit   started = 1'b0;
   exp_t qa[$], qb[$], qc[$];
   vec_t tbl[15];

   function automatic exp_t model(int k, int div, int hv, int hf, int hs, int hb,
                                  int vv, int vf, int vs, int vb, bit pol);
      exp_t e;
      int ht = hv + hf + hs + hb;
      int vt = vv + vf + vs + vb;
      int a  = k / div;
      int p  = a % (ht * vt);
      int h  = p % ht;
      int v  = p / ht;
      e.pix_tick  = (k > 0) && (k % div == 0);
      e.pos_h     = 10'(h);
      e.pos_v     = 10'(v);
      e.blank     = (h >= hv) || (v >= vv);
      e.hsync     = (h >= hv + hf && h < hv + hf + hs) ? pol : ~pol;
      e.vsync     = (v >= vv + vf && v < vv + vf + vs) ? pol : ~pol;
      e.update    = e.pix_tick && (h == 0) && (v == vv);
      e.frame_cnt = 16'(a / (ht * vt));
      return e;
   endfunction

   function automatic exp_t mk_e(bit t, int h, int v, bit b, bit hs, bit vs, bit u, int fc);
      exp_t e;
      e.pix_tick = t; e.pos_h = 10'(h); e.pos_v = 10'(v); e.blank = b;
      e.hsync = hs; e.vsync = vs; e.update = u; e.frame_cnt = 16'(fc);
      return e;
   endfunction

   function automatic vec_t mk(int k, bit t, int h, int v, bit b, bit hs, bit vs, bit u, int fc);
      vec_t r;
      r.k = k;
      r.e = mk_e(t, h, v, b, hs, vs, u, fc);
      return r;
   endfunction

   function automatic exp_t pack_a();
      exp_t e;
      e.pix_tick = ia.pix_tick; e.pos_h = ia.pos_h; e.pos_v = ia.pos_v; e.blank = ia.blank;
      e.hsync = ia.hsync; e.vsync = ia.vsync; e.update = ia.update; e.frame_cnt = ia.frame_cnt;
      return e;
   endfunction

   function automatic exp_t pack_b();
      exp_t e;
      e.pix_tick = ib.pix_tick; e.pos_h = ib.pos_h; e.pos_v = ib.pos_v; e.blank = ib.blank;
      e.hsync = ib.hsync; e.vsync = ib.vsync; e.update = ib.update; e.frame_cnt = ib.frame_cnt;
      return e;
   endfunction

   function automatic exp_t pack_c();
      exp_t e;
      e.pix_tick = ic.pix_tick; e.pos_h = ic.pos_h; e.pos_v = ic.pos_v; e.blank = ic.blank;
      e.hsync = ic.hsync; e.vsync = ic.vsync; e.update = ic.update; e.frame_cnt = ic.frame_cnt;
      return e;
   endfunction

   function automatic void chk_vec(string name, exp_t act, exp_t exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s k=%0d got tick=%0b h=%0d v=%0d blank=%0b hs=%0b vs=%0b upd=%0b fc=%0d want tick=%0b h=%0d v=%0d blank=%0b hs=%0b vs=%0b upd=%0b fc=%0d",
                  name, kcnt, act.pix_tick, act.pos_h, act.pos_v, act.blank, act.hsync,
                  act.vsync, act.update, act.frame_cnt, exp.pix_tick, exp.pos_h, exp.pos_v,
                  exp.blank, exp.hsync, exp.vsync, exp.update, exp.frame_cnt);
      end
   endfunction

   function automatic void chk_int(string name, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s k=%0d got=%0d want=%0d", name, kcnt, act, exp);
      end
   endfunction

   // Scoreboard producer: expected outputs for the edge just taken.
   initial begin
      forever begin
         @(posedge clk);
         if (rst) begin
            kcnt    = 0;
            started = 1'b1;
         end else if (started) begin
            kcnt++;
         end
         if (started) begin
            qa.push_back(model(kcnt, 4, 16, 2, 4, 3, 10, 2, 2, 3, 1'b0));
            qb.push_back(model(kcnt, 1, 16, 2, 4, 3, 10, 2, 2, 3, 1'b1));
            qc.push_back(model(kcnt, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0));
         end
      end
   end

   // Scoreboard consumer.
   initial begin
      forever begin
         @(negedge clk);
         if (started) begin
            if (qa.size() == 0 || qb.size() == 0 || qc.size() == 0) begin
               chk_int("queue_empty", 0, 1);
            end else begin
               chk_vec("model_a", pack_a(), qa.pop_front());
               chk_vec("model_b", pack_b(), qb.pop_front());
               chk_vec("model_c", pack_c(), qc.pop_front());
            end
         end
      end
   end

   // Multi-cycle properties: update period, hsync width, active pixels per frame.
   int last_upd_a = -1;
   int last_upd_b = -1;
   int hs_cnt     = 0;
   int act_cnt    = 1;
   initial begin
      forever begin
         @(negedge clk);
         if (started) begin
            if (kcnt == 0) begin
               last_upd_a = -1;
               last_upd_b = -1;
               hs_cnt     = 0;
               act_cnt    = 1;
            end else begin
               if (ia.update) begin
                  if (last_upd_a >= 0) chk_int("update_period_a", kcnt - last_upd_a, 1700);
                  last_upd_a = kcnt;
               end
               if (ib.update) begin
                  if (last_upd_b >= 0) chk_int("update_period_b", kcnt - last_upd_b, 425);
                  last_upd_b = kcnt;
               end
               if (ia.pix_tick) begin
                  if (ia.pos_h == 10'd0) begin
                     chk_int("hsync_width_a", hs_cnt, 4);
                     hs_cnt = 0;
                  end
                  if (ia.hsync == 1'b0) hs_cnt++;
                  if (ia.pos_h == 10'd0 && ia.pos_v == 10'd0) begin
                     chk_int("active_pixels_a", act_cnt, 160);
                     act_cnt = 0;
                  end
                  if (!ia.blank) act_cnt++;
               end
            end
         end
      end
   end

   task automatic run_table();
      for (int i = 0; i < 15; i++) begin
         repeat (tbl[i].k - kcnt) @(negedge clk);
         chk_vec($sformatf("table_a[%0d]", i), pack_a(), tbl[i].e);
      end
   endtask

   initial begin
      //           k     tick h   v   blank hs vs upd fc
      tbl[0]  = mk(1,    0,   0,  0,  0,    1, 1, 0,  0);
      tbl[1]  = mk(4,    1,   1,  0,  0,    1, 1, 0,  0);
      tbl[2]  = mk(60,   1,   15, 0,  0,    1, 1, 0,  0);
      tbl[3]  = mk(64,   1,   16, 0,  1,    1, 1, 0,  0);
      tbl[4]  = mk(72,   1,   18, 0,  1,    0, 1, 0,  0);
      tbl[5]  = mk(87,   0,   21, 0,  1,    0, 1, 0,  0);
      tbl[6]  = mk(88,   1,   22, 0,  1,    1, 1, 0,  0);
      tbl[7]  = mk(100,  1,   0,  1,  0,    1, 1, 0,  0);
      tbl[8]  = mk(1000, 1,   0,  10, 1,    1, 1, 1,  0);
      tbl[9]  = mk(1004, 1,   1,  10, 1,    1, 1, 0,  0);
      tbl[10] = mk(1200, 1,   0,  12, 1,    1, 0, 0,  0);
      tbl[11] = mk(1396, 1,   24, 13, 1,    1, 0, 0,  0);
      tbl[12] = mk(1400, 1,   0,  14, 1,    1, 1, 0,  0);
      tbl[13] = mk(1700, 1,   0,  0,  0,    1, 1, 0,  1);
      tbl[14] = mk(3400, 1,   0,  0,  0,    1, 1, 0,  2);

      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_vec("reset_a", pack_a(), mk_e(0, 0, 0, 0, 1, 1, 0, 0));
      chk_vec("reset_b", pack_b(), mk_e(0, 0, 0, 0, 0, 0, 0, 0));
      rst = 1'b0;
      run_table();

      // Mid-frame reset at (10,5) of the third frame.
      repeat (3940 - kcnt) @(negedge clk);
      chk_vec("pre_reset_a", pack_a(), mk_e(1, 10, 5, 0, 1, 1, 0, 2));
      rst = 1'b1;
      @(negedge clk);
      chk_vec("mid_reset_a", pack_a(), mk_e(0, 0, 0, 0, 1, 1, 0, 0));
      chk_vec("mid_reset_c", pack_c(), mk_e(0, 0, 0, 0, 1, 1, 0, 0));
      rst = 1'b0;
      run_table();

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
